// File: rtl/gamma_lut_loader_if.sv
// Host entry stream plus LUT RAM write port of the gamma table loader.
// Latency: none (signal bundle only).
// Backpressure: the loader is the slave on wr_*; the RAM port has no backpressure.
interface gamma_lut_loader_if #(
   parameter int COLOR_W    = 7,
   parameter int DEPTH_LOG2 = 7
);
   logic                  wr_valid_i;
   logic [COLOR_W-1:0]    wr_data_i;
   logic                  wr_ready_o;
   logic                  ram_we_o;
   logic [DEPTH_LOG2:0]   ram_addr_o;
   logic [COLOR_W-1:0]    ram_wdata_o;

   // loader side
   modport slave (
      input  wr_valid_i, wr_data_i,
      output wr_ready_o, ram_we_o, ram_addr_o, ram_wdata_o
   );

   // host / RAM side
   modport master (
      output wr_valid_i, wr_data_i,
      input  wr_ready_o, ram_we_o, ram_addr_o, ram_wdata_o
   );
endinterface

// File: rtl/gamma_lut_loader.sv
// Loads a full gamma curve into the inactive LUT bank, then swaps banks on a qualified vsync.
// Latency: RAM write one cycle after each accepted entry; bank swap one cycle after the swap cycle.
// Backpressure: wr_ready_o is high only in LOAD, a registered state decode.
module gamma_lut_loader #(
   parameter int COLOR_W    = 7,
   parameter int DEPTH_LOG2 = 7
) (
   input  logic                  VCLK,
   input  logic                  RST,
   input  logic                  nVDSYNC,
   input  logic                  vsync_i,
   input  logic                  load_start_i,
   gamma_lut_loader_if.slave     bus,
   output logic                  active_bank_o,
   output logic                  busy_o,
   output logic                  swap_done_o,
   output logic                  err_o
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PEND} state_t;

   localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

   state_t                  r_state;
   state_t                  w_next;
   logic [DEPTH_LOG2-1:0]   r_idx;
   logic                    r_we;
   logic [DEPTH_LOG2:0]     r_addr;
   logic [COLOR_W-1:0]      r_wdata;
   logic                    r_active;
   logic                    r_swap_done;
   logic                    r_err;
   logic                    w_rdy;
   logic                    w_busy;
   logic                    w_xfer;
   logic                    w_last;
   logic                    w_swap;

   assign w_xfer = bus.wr_valid_i & w_rdy;
   assign w_last = w_xfer & (r_idx == LAST_IDX);
   // a restart in PENDING cancels the swap even if vsync qualifies in the same cycle
   assign w_swap = (r_state == S_PEND) & ~load_start_i & ~nVDSYNC & vsync_i;

   // state register
   always_ff @(posedge VCLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next-state logic; load_start_i has priority in every state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (load_start_i) w_next = S_LOAD;
         S_LOAD:  if (load_start_i) w_next = S_LOAD;
                  else if (w_last)  w_next = S_PEND;
         S_PEND:  if (load_start_i) w_next = S_LOAD;
                  else if (w_swap)  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // outputs decoded from the registered state
   always_comb begin
      w_rdy  = (r_state == S_LOAD);
      w_busy = (r_state == S_LOAD) | (r_state == S_PEND);
   end

   // entry index: restarts on every load_start, holds through host stalls
   always_ff @(posedge VCLK or posedge RST) begin
      if (RST)               r_idx <= '0;
      else if (load_start_i) r_idx <= '0;
      else if (w_xfer)       r_idx <= r_idx + 1'b1;
   end

   // registered RAM write port; bank bit always targets the inactive bank
   always_ff @(posedge VCLK or posedge RST) begin
      if (RST) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_we <= w_xfer;
         if (w_xfer) begin
            r_addr  <= {~r_active, r_idx};
            r_wdata <= bus.wr_data_i;
         end
      end
   end

   // active bank toggle and its one-cycle completion pulse
   always_ff @(posedge VCLK or posedge RST) begin
      if (RST) begin
         r_active    <= 1'b0;
         r_swap_done <= 1'b0;
      end else begin
         r_swap_done <= w_swap;
         if (w_swap) r_active <= ~r_active;
      end
   end

   // sticky error for host entries offered outside LOAD
   always_ff @(posedge VCLK or posedge RST) begin
      if (RST)                              r_err <= 1'b0;
      else if (load_start_i)                r_err <= 1'b0;
      else if (bus.wr_valid_i & ~w_rdy)     r_err <= 1'b1;
   end

   assign bus.wr_ready_o  = w_rdy;
   assign bus.ram_we_o    = r_we;
   assign bus.ram_addr_o  = r_addr;
   assign bus.ram_wdata_o = r_wdata;
   assign active_bank_o   = r_active;
   assign busy_o          = w_busy;
   assign swap_done_o     = r_swap_done;
   assign err_o           = r_err;

endmodule

// File: tb/tb_gamma_lut_loader.sv
// Self-checking bench for gamma_lut_loader: scoreboarded RAM writes plus a control vector table.
// Latency: n/a.
// Backpressure: n/a.
module tb_gamma_lut_loader;

   localparam int CW = 7;
   localparam int DL = 7;

   typedef struct packed {
      logic [DL:0]   addr;
      logic [CW-1:0] dat;
   } wr_t;

   typedef struct {
      logic ls, nvd, vs, wv;
      logic e_bank, e_busy, e_sd, e_err, e_rdy;
   } vec_t;

   logic VCLK, RST, nVDSYNC, vsync_i, load_start_i;
   logic active_bank_o, busy_o, swap_done_o, err_o;

   gamma_lut_loader_if #(.COLOR_W(CW), .DEPTH_LOG2(DL)) bus ();

   gamma_lut_loader #(.COLOR_W(CW), .DEPTH_LOG2(DL)) dut (
      .VCLK          (VCLK),
      .RST           (RST),
      .nVDSYNC       (nVDSYNC),
      .vsync_i       (vsync_i),
      .load_start_i  (load_start_i),
      .bus           (bus),
      .active_bank_o (active_bank_o),
      .busy_o        (busy_o),
      .swap_done_o   (swap_done_o),
      .err_o         (err_o)
   );

   int  n_vec = 0;
   int  n_err = 0;
   int  n_wr  = 0;
   int  n_sd  = 0;
   wr_t sb[$];

   initial begin
      VCLK = 1'b0;
      forever #5 VCLK = ~VCLK;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // RAM write monitor: every write must match the oldest expected entry
   always @(negedge VCLK) begin
      if (swap_done_o === 1'b1) n_sd++;
      if (bus.ram_we_o === 1'b1) begin
         wr_t e;
         n_wr++;
         if (sb.size() == 0) begin
            chk("unexpected_ram_write_addr", int'(bus.ram_addr_o), -1);
         end else begin
            e = sb.pop_front();
            chk("ram_addr", int'(bus.ram_addr_o), int'(e.addr));
            chk("ram_wdata", int'(bus.ram_wdata_o), int'(e.dat));
         end
      end
   end

   task automatic step();
      @(posedge VCLK);
      #1;
   endtask

   task automatic pulse_start();
      load_start_i = 1'b1;
      step();
      load_start_i = 1'b0;
   endtask

   // back-to-back entries from index 0; bank is the one the writes must target
   task automatic send(input int n, input logic bank, input int dbase);
      for (int i = 0; i < n; i++) begin
         wr_t e;
         bus.wr_valid_i = 1'b1;
         bus.wr_data_i  = CW'(dbase + i);
         e.addr = {bank, DL'(i)};
         e.dat  = CW'(dbase + i);
         sb.push_back(e);
         step();
         chk1("busy_during_load", busy_o, 1'b1);
      end
      bus.wr_valid_i = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk1({tag, "_ram_we"}, bus.ram_we_o, 1'b0);
      chk({tag, "_ram_addr"}, int'(bus.ram_addr_o), 0);
      chk({tag, "_ram_wdata"}, int'(bus.ram_wdata_o), 0);
      chk1({tag, "_active_bank"}, active_bank_o, 1'b0);
      chk1({tag, "_busy"}, busy_o, 1'b0);
      chk1({tag, "_swap_done"}, swap_done_o, 1'b0);
      chk1({tag, "_err"}, err_o, 1'b0);
      chk1({tag, "_wr_ready"}, bus.wr_ready_o, 1'b0);
   endtask

   vec_t vt[9];
   int   base;

   initial begin
      // control vectors, applied from PENDING with bank 0 and err clear
      //          ls    nvd   vs    wv    bank  busy  sd    err   rdy
      vt[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

      RST = 1'b0; nVDSYNC = 1'b1; vsync_i = 1'b0; load_start_i = 1'b0;
      bus.wr_valid_i = 1'b0; bus.wr_data_i = '0;
      #2 RST = 1'b1;
      #1 chk_all_zero("reset");
      repeat (2) step();
      RST = 1'b0;
      step();

      // full load, swap qualified from the first PENDING cycle
      nVDSYNC = 1'b0; vsync_i = 1'b1;
      base = n_wr;
      pulse_start();
      send(128, 1'b1, 0);
      chk1("t1_pend_we", bus.ram_we_o, 1'b1);
      chk("t1_last_addr", int'(bus.ram_addr_o), 8'hFF);
      chk("t1_last_data", int'(bus.ram_wdata_o), 127);
      chk1("t1_bank_before", active_bank_o, 1'b0);
      chk1("t1_sd_before", swap_done_o, 1'b0);
      step();
      chk1("t1_bank_after", active_bank_o, 1'b1);
      chk1("t1_swap_done", swap_done_o, 1'b1);
      chk1("t1_busy_after", busy_o, 1'b0);
      chk("t1_write_count", n_wr - base, 128);
      chk("t1_sb_empty", sb.size(), 0);
      step();
      chk1("t1_sd_single", swap_done_o, 1'b0);

      // second load targets bank 0 and swaps back
      pulse_start();
      send(128, 1'b0, 3);
      chk("t2_last_addr", int'(bus.ram_addr_o), 8'h7F);
      step();
      chk1("t2_bank_after", active_bank_o, 1'b0);
      chk1("t2_swap_done", swap_done_o, 1'b1);
      step();
      nVDSYNC = 1'b1; vsync_i = 1'b0;

      // partial load discarded by a restart
      base = n_wr;
      pulse_start();
      send(50, 1'b1, 10);
      pulse_start();
      send(128, 1'b1, 20);
      chk("t3_last_addr", int'(bus.ram_addr_o), 8'hFF);
      step();
      chk("t3_write_count", n_wr - base, 178);
      chk("t3_sb_empty", sb.size(), 0);

      // long PENDING dwell without vsync
      repeat (1000) step();
      chk1("t4_bank_held", active_bank_o, 1'b0);
      chk1("t4_busy_held", busy_o, 1'b1);
      chk("t4_swap_count", n_sd, 2);

      // control vector table: nVDSYNC qualification, IDLE error, restart
      bus.wr_data_i = 7'h2A;
      for (int v = 0; v < 9; v++) begin
         load_start_i   = vt[v].ls;
         nVDSYNC        = vt[v].nvd;
         vsync_i        = vt[v].vs;
         bus.wr_valid_i = vt[v].wv;
         step();
         chk1($sformatf("vec%0d_bank", v), active_bank_o, vt[v].e_bank);
         chk1($sformatf("vec%0d_busy", v), busy_o, vt[v].e_busy);
         chk1($sformatf("vec%0d_swap_done", v), swap_done_o, vt[v].e_sd);
         chk1($sformatf("vec%0d_err", v), err_o, vt[v].e_err);
         chk1($sformatf("vec%0d_wr_ready", v), bus.wr_ready_o, vt[v].e_rdy);
      end
      load_start_i = 1'b0; bus.wr_valid_i = 1'b0; nVDSYNC = 1'b1; vsync_i = 1'b0;

      // restart in PENDING collides with a qualified swap: restart wins
      send(128, 1'b0, 40);
      load_start_i = 1'b1; nVDSYNC = 1'b0; vsync_i = 1'b1;
      step();
      load_start_i = 1'b0;
      chk1("t5_bank_kept", active_bank_o, 1'b1);
      chk1("t5_no_swap", swap_done_o, 1'b0);
      chk1("t5_ready", bus.wr_ready_o, 1'b1);
      chk1("t5_busy", busy_o, 1'b1);

      // idx restarted at 0 (checked by the scoreboard); reset at entry 64
      send(64, 1'b0, 60);
      @(negedge VCLK);
      #1 RST = 1'b1;
      #1 chk_all_zero("midload_reset");
      repeat (3) step();
      RST = 1'b0;
      repeat (3) step();
      chk1("post_reset_busy", busy_o, 1'b0);
      chk1("post_reset_bank", active_bank_o, 1'b0);
      chk("final_sb_empty", sb.size(), 0);
      chk("final_swap_count", n_sd, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gamma_lut_loader.md
# gamma_lut_loader

Write-side controller for the RAM-based gamma lookup tables. Accepts a full 128-entry gamma curve from the host (NIOS/controller side) over a valid/ready stream and writes it into the inactive bank of a double-banked LUT RAM. It then swaps the active bank only during vertical sync, on an nVDSYNC-qualified cycle. This avoids visible tearing. The gamma readers in the PPU consume `ram_*` and `active_bank_o`.

## Interface
Parameters:
- `COLOR_W`, default 7: bits per colour entry and LUT data width.
- `DEPTH_LOG2`, default 7: log2 of entries per bank (128).

Ports:
- `VCLK`, in, 1: video clock; the only clock.
- `RST`, in, 1: reset, asynchronous, active-high.
- `nVDSYNC`, in, 1: data-valid strobe, active-low; swaps are qualified on it.
- `vsync_i`, in, 1: vertical sync flag of the current pixel, sampled when `nVDSYNC` is low.
- `load_start_i`, in, 1: one-cycle pulse; starts or restarts a table load.
- `wr_valid_i`, in, 1: host entry valid.
- `wr_data_i`, in, `COLOR_W`: host entry value. Entries are sent in index order 0..127.
- `wr_ready_o`, out, 1: block accepts an entry.
- `ram_we_o`, out, 1: LUT RAM write enable.
- `ram_addr_o`, out, `DEPTH_LOG2+1`: LUT address; MSB is the bank, LSBs are the index.
- `ram_wdata_o`, out, `COLOR_W`: LUT write data.
- `active_bank_o`, out, 1: bank the readers use.
- `busy_o`, out, 1: high in LOAD or PENDING.
- `swap_done_o`, out, 1: one-cycle pulse when the bank swaps.
- `err_o`, out, 1: sticky protocol error.

## Operation
- States:
  - IDLE: `wr_ready_o` = 0.
  - LOAD: `wr_ready_o` = 1.
  - PENDING: `wr_ready_o` = 0; the table is complete and waits for the swap.
- A transfer happens on any cycle with `wr_valid_i` & `wr_ready_o`. Index counter `idx` (`DEPTH_LOG2` bits) increments on each transfer.
- IDLE -> LOAD on `load_start_i`. On this transition `idx` <= 0 and `err_o` <= 0.
- LOAD -> PENDING on the transfer with `idx` == 127. `idx` wraps to 0.
- LOAD, `load_start_i`: stay in LOAD, `idx` <= 0, `err_o` <= 0. A partial load is discarded.
- PENDING -> IDLE when `!nVDSYNC` & `vsync_i`. In that transition `active_bank_o` toggles and `swap_done_o` pulses.
- PENDING, `load_start_i`: go to LOAD, `idx` <= 0, and cancel the pending swap. If `load_start_i` and the swap condition occur in the same cycle, `load_start_i` wins and no swap happens.
- Write port (registered): a transfer at cycle n produces the following at cycle n+1:
  - `ram_we_o` = 1
  - `ram_addr_o` = {~`active_bank_o`, idx_at_n}
  - `ram_wdata_o` = `wr_data_i`_at_n

  Otherwise `ram_we_o` = 0, and `ram_addr_o`/`ram_wdata_o` hold their last values.
- The block never writes the active bank. The bank bit is computed from `active_bank_o` at cycle n; this is safe because no swap can occur in LOAD.
- `wr_valid_i` high while not in LOAD sets `err_o` = 1. The data is ignored. `err_o` clears only on `load_start_i` or reset.
- `busy_o` = (state == LOAD) | (state == PENDING), decoded from registered state.

## Timing
- Reset values: state IDLE, `idx` 0, and all outputs 0 (`active_bank_o` 0, `ram_addr_o` 0, `ram_wdata_o` 0).
- Reset asserted mid-load or in PENDING: immediate return to IDLE. `active_bank_o` returns to 0. No further RAM write is issued. The partial table is discarded.
- `wr_ready_o` is a registered state decode.
- A load with no stalls takes 128 cycles. The first cycle of LOAD is the cycle after the `load_start_i` pulse.
- The last RAM write (index 127) occurs in the same cycle PENDING is entered. The earliest swap is therefore evaluated in that cycle, and `active_bank_o` changes one cycle later. Readers see the new bank no earlier than one cycle after the last write.
- `swap_done_o` is high in the same cycle that `active_bank_o` first shows the new value.
- Host stalls (`wr_valid_i` low) may last any length; `idx` holds.

## Test plan
- Reset, `load_start_i`, then 128 back-to-back entries with `wr_data_i` = index. Required: writes at addresses 0x80..0xFF with data 0..127, one per cycle, and `busy_o` = 1. With `vsync_i` = 1 and `nVDSYNC` low: `active_bank_o` 0->1 and one `swap_done_o` pulse.
- Second full load after the first swap. Required: writes target addresses 0x00..0x7F, then the swap returns `active_bank_o` to 0.
- 50 entries, then `load_start_i`, then 128 entries. Required: `idx` restarts at 0, the total RAM write count is 178, and the final writes cover 0x80..0xFF.
- Load completes with `vsync_i` = 0 for 1000 cycles. Required: `active_bank_o` is unchanged and `busy_o` = 1. Then `vsync_i` = 1 with `nVDSYNC` high for 3 cycles: no swap. Then `nVDSYNC` goes low: swap.
- PENDING with `load_start_i` and the swap condition in the same cycle. Required: no swap, state LOAD, `idx` = 0.
- `wr_valid_i` pulsed in IDLE. Required: `err_o` = 1, no `ram_we_o`. `err_o` clears on the next `load_start_i`. Also assert `RST` at entry 64: all outputs go to 0 immediately.
